// File: rtl/control_unit.sv
// control_unit: main opcode decoder for the single-cycle MIPS datapath.
// Decodes instruction bits [31:26] into registered datapath steering signals.
// Unsupported opcodes decode to an all-zero NOP and raise illegal_op.
// Optional feature macro: CONTROL_UNIT_ADDI_EN (adds the addi opcode 001000).
module control_unit (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    output logic       RegDst,
    output logic       Jump,
    output logic       Branch,
    output logic       MemRead,
    output logic       MemtoReg,
    output logic [1:0] ALUop,
    output logic       MemWrite,
    output logic       ALUSrc,
    output logic       RegWrite,
    output logic       illegal_op
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
`ifdef CONTROL_UNIT_ADDI_EN
    localparam logic [5:0] OP_ADDI  = 6'b001000;
`endif

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    logic       decRegDst;
    logic       decJump;
    logic       decBranch;
    logic       decMemRead;
    logic       decMemtoReg;
    logic [1:0] decALUop;
    logic       decMemWrite;
    logic       decALUSrc;
    logic       decRegWrite;
    logic       decIllegal;

    // Combinational opcode decode; everything defaults to the safe NOP and
    // each supported opcode raises only the controls it needs.
    always_comb begin
        decRegDst   = 1'b0;
        decJump     = 1'b0;
        decBranch   = 1'b0;
        decMemRead  = 1'b0;
        decMemtoReg = 1'b0;
        decALUop    = ALU_ADD;
        decMemWrite = 1'b0;
        decALUSrc   = 1'b0;
        decRegWrite = 1'b0;
        decIllegal  = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                decRegDst   = 1'b1;
                decALUop    = ALU_FUNCT;
                decRegWrite = 1'b1;
            end
            OP_LW: begin
                decMemRead  = 1'b1;
                decMemtoReg = 1'b1;
                decALUSrc   = 1'b1;
                decRegWrite = 1'b1;
            end
            OP_SW: begin
                decMemWrite = 1'b1;
                decALUSrc   = 1'b1;
            end
            OP_BEQ: begin
                decBranch   = 1'b1;
                decALUop    = ALU_SUB;
            end
            OP_J: begin
                decJump     = 1'b1;
            end
`ifdef CONTROL_UNIT_ADDI_EN
            OP_ADDI: begin
                decALUSrc   = 1'b1;
                decRegWrite = 1'b1;
            end
`endif
            default: begin
                decIllegal  = 1'b1;
            end
        endcase
    end

    // Output register: one cycle of latency, cleared to NOP asynchronously
    // so an in-flight decode is discarded the moment reset asserts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            RegDst     <= 1'b0;
            Jump       <= 1'b0;
            Branch     <= 1'b0;
            MemRead    <= 1'b0;
            MemtoReg   <= 1'b0;
            ALUop      <= 2'b00;
            MemWrite   <= 1'b0;
            ALUSrc     <= 1'b0;
            RegWrite   <= 1'b0;
            illegal_op <= 1'b0;
        end else begin
            RegDst     <= decRegDst;
            Jump       <= decJump;
            Branch     <= decBranch;
            MemRead    <= decMemRead;
            MemtoReg   <= decMemtoReg;
            ALUop      <= decALUop;
            MemWrite   <= decMemWrite;
            ALUSrc     <= decALUSrc;
            RegWrite   <= decRegWrite;
            illegal_op <= decIllegal;
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: self-checking bench for control_unit.
// Honours CONTROL_UNIT_ADDI_EN so expectations follow the build under test.
module tb_control_unit;

    logic       clk;
    logic       rst_n;
    logic [5:0] opcode;
    logic       RegDst;
    logic       Jump;
    logic       Branch;
    logic       MemRead;
    logic       MemtoReg;
    logic [1:0] ALUop;
    logic       MemWrite;
    logic       ALUSrc;
    logic       RegWrite;
    logic       illegal_op;

    int testsRun;
    int testsFailed;

    // Packed view, order: RegDst,Jump,Branch,MemRead,MemtoReg,ALUop,MemWrite,ALUSrc,RegWrite,illegal_op
    logic [10:0] observed;
    assign observed = {RegDst, Jump, Branch, MemRead, MemtoReg, ALUop,
                       MemWrite, ALUSrc, RegWrite, illegal_op};

    localparam logic [10:0] NOP     = 11'b0_0_0_0_0_00_0_0_0_0;
    localparam logic [10:0] ILLEGAL = 11'b0_0_0_0_0_00_0_0_0_1;
    localparam logic [10:0] EXP_R   = 11'b1_0_0_0_0_10_0_0_1_0;
    localparam logic [10:0] EXP_LW  = 11'b0_0_0_1_1_00_0_1_1_0;
    localparam logic [10:0] EXP_SW  = 11'b0_0_0_0_0_00_1_1_0_0;
    localparam logic [10:0] EXP_BEQ = 11'b0_0_1_0_0_01_0_0_0_0;
    localparam logic [10:0] EXP_J   = 11'b0_1_0_0_0_00_0_0_0_0;
`ifdef CONTROL_UNIT_ADDI_EN
    localparam logic [10:0] EXP_ADDI = 11'b0_0_0_0_0_00_0_1_1_0;
`else
    localparam logic [10:0] EXP_ADDI = ILLEGAL;
`endif

    typedef struct {
        logic [5:0]  op;
        logic [10:0] expected;
        string       name;
    } vector_t;

    vector_t vectors [10];

    // Reference model: opcode -> control word for supported opcodes only;
    // anything missing from the map is illegal.
    logic [10:0] refTable [logic [5:0]];

    control_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode     (opcode),
        .RegDst     (RegDst),
        .Jump       (Jump),
        .Branch     (Branch),
        .MemRead    (MemRead),
        .MemtoReg   (MemtoReg),
        .ALUop      (ALUop),
        .MemWrite   (MemWrite),
        .ALUSrc     (ALUSrc),
        .RegWrite   (RegWrite),
        .illegal_op (illegal_op)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [10:0] modelDecode(input logic [5:0] op);
        if (refTable.exists(op)) return refTable[op];
        return ILLEGAL;
    endfunction

    task automatic checkOutput(input string name, input logic [10:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %b required %b", name, observed, expected);
        end
    endtask

    task automatic checkBit(input string name, input logic got, input logic expected);
        testsRun++;
        if (got !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %b required %b", name, got, expected);
        end
    endtask

    // Drive an opcode, let one rising edge latch it, then sample 1 time unit later.
    task automatic applyStimulus(input logic [5:0] op);
        opcode = op;
        @(posedge clk);
        #1;
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;

        refTable[6'b000000] = EXP_R;
        refTable[6'b100011] = EXP_LW;
        refTable[6'b101011] = EXP_SW;
        refTable[6'b000100] = EXP_BEQ;
        refTable[6'b000010] = EXP_J;
`ifdef CONTROL_UNIT_ADDI_EN
        refTable[6'b001000] = EXP_ADDI;
`endif

        vectors[0] = '{6'b000000, EXP_R,    "rtype"};
        vectors[1] = '{6'b100011, EXP_LW,   "lw"};
        vectors[2] = '{6'b101011, EXP_SW,   "sw"};
        vectors[3] = '{6'b000100, EXP_BEQ,  "beq"};
        vectors[4] = '{6'b000010, EXP_J,    "jump"};
        vectors[5] = '{6'b111111, ILLEGAL,  "illegal_3f"};
        vectors[6] = '{6'b000001, ILLEGAL,  "illegal_01"};
        vectors[7] = '{6'b100011, EXP_LW,   "lw_after_illegal"};
        vectors[8] = '{6'b001000, EXP_ADDI, "addi"};
        vectors[9] = '{6'b001000, EXP_ADDI, "addi_repeat"};

        // Reset held with R-type on the input: outputs stay NOP across edges.
        rst_n  = 1'b0;
        opcode = 6'b000000;
        #2;
        checkOutput("reset_immediate", NOP);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_held", NOP);

        // Release between edges; first edge latches the R-type opcode.
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("first_after_reset", EXP_R);

        // Table-driven consecutive opcodes, one cycle apart.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vectors[i].op);
            checkOutput(vectors[i].name, vectors[i].expected);
        end

        // Back-to-back identical opcodes: outputs must hold across the edge.
        applyStimulus(6'b101011);
        checkOutput("sw_hold_a", EXP_SW);
        #3;
        checkOutput("sw_hold_mid", EXP_SW);
        applyStimulus(6'b101011);
        checkOutput("sw_hold_b", EXP_SW);

        // Asynchronous reset between edges discards the latched lw.
        applyStimulus(6'b100011);
        checkOutput("lw_before_async", EXP_LW);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_reset_clears", NOP);
        @(posedge clk);
        #1;
        checkOutput("async_reset_held", NOP);
        #2 rst_n = 1'b1;
        applyStimulus(6'b000100);
        checkOutput("beq_after_async", EXP_BEQ);

        // Randomized opcodes, half drawn from the supported set.
        for (int i = 0; i < 300; i++) begin
            logic [5:0] op;
            if ($urandom_range(0, 1) == 0) begin
                case ($urandom_range(0, 5))
                    0: op = 6'b000000;
                    1: op = 6'b100011;
                    2: op = 6'b101011;
                    3: op = 6'b000100;
                    4: op = 6'b000010;
                    default: op = 6'b001000;
                endcase
            end else begin
                op = 6'($urandom_range(0, 63));
            end
            applyStimulus(op);
            checkOutput($sformatf("random_%0d_op%b", i, op), modelDecode(op));
            checkBit("mem_rw_exclusive", MemRead & MemWrite, 1'b0);
            checkBit("jump_branch_exclusive", Jump & Branch, 1'b0);
            checkBit("aluop_not_reserved", &ALUop, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
